banked_sram: RTL and testbench

- Parametrised, banked successor to the 8K cartridge/work SRAM model. Covers the CGB 8×4K WRAM (SVBK-style bank register) and multi-bank cartridge RAM.
- Adds four things the single-bank model lacks: a bank-select register, a post-reset memory-clear sequencer, a registered read with a valid strobe, and an open-bus 0xFF return.
- Sits behind the address decoder on the CPU bus.

---
 rtl/gb_mem_pkg.sv | 15 +
 rtl/banked_sram_if.sv | 29 ++
 rtl/sp_ram_sync.sv | 26 ++
 rtl/banked_sram.sv | 98 +++++++++
 tb/tb_banked_sram.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/gb_mem_pkg.sv
// Shared constants and types for the banked SRAM family: open-bus value, FSM states, depth helper.
package gb_mem_pkg;

  localparam logic [63:0] OPEN_BUS = '1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } sram_state_t;

  function automatic int total_depth(input int banks, input int addr_w);
    return banks << addr_w;
  endfunction

endpackage

// File: rtl/banked_sram_if.sv
// CPU-side bus of the banked SRAM: access strobes, bank register load and the read/status returns.
interface banked_sram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
);

  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D_in;
  logic              CS;
  logic              WR;
  logic              RD;
  logic              bank_wr;
  logic [7:0]        bank_din;
  logic [DATA_W-1:0] D_out;
  logic              rd_valid;
  logic [7:0]        bank_q;
  logic              busy;

  modport master (
    output A, D_in, CS, WR, RD, bank_wr, bank_din,
    input  D_out, rd_valid, bank_q, busy
  );

  modport slave (
    input  A, D_in, CS, WR, RD, bank_wr, bank_din,
    output D_out, rd_valid, bank_q, busy
  );

endinterface

// File: rtl/sp_ram_sync.sv
// Single-port synchronous RAM; 1-cycle registered read, write-first on the read port.
// No backpressure: one access accepted every cycle.
module sp_ram_sync #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
      q         <= din;
    end else begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/banked_sram.sv
// Banked SRAM with bank register, post-reset clear sequencer and open-bus 0xFF return; read latency 1.
// No backpressure: CPU accesses and bank loads arriving while busy are dropped, not queued.
module banked_sram
  import gb_mem_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 12,
  parameter int                BANKS      = 8,
  parameter int                BANK0_AS_1 = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL  = '0,
  parameter int                CLEAR_EN   = 1
) (
  input  logic clk,
  input  logic rst,
  banked_sram_if.slave bus
);

  localparam int BW    = $clog2(BANKS);
  localparam int DEPTH = total_depth(BANKS, ADDR_W);
  localparam int LA    = BW + ADDR_W;

  sram_state_t       state;
  logic [LA-1:0]     clr_cnt;
  logic [BW-1:0]     bank_reg;
  logic [BW-1:0]     eb;
  logic              rd_pend;
  logic              clearing;
  logic              ram_we;
  logic [LA-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_q;
  logic              unused_bank_hi;

  assign clearing       = (state == CLEAR);
  assign unused_bank_hi = ^bus.bank_din[7:BW];

  always_comb begin
    eb = bank_reg;
    if ((BANK0_AS_1 != 0) && (bank_reg == '0)) begin
      eb = BW'(1);
    end
  end

  // The clearer owns the RAM port outright; nothing touches memory while rst is held.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = {eb, bus.A};
    ram_din  = bus.D_in;
    if (rst) begin
      ram_we = 1'b0;
    end else if (clearing) begin
      ram_we   = 1'b1;
      ram_addr = clr_cnt;
      ram_din  = CLEAR_VAL;
    end else begin
      ram_we = bus.CS & bus.WR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= (CLEAR_EN != 0) ? CLEAR : READY;
      clr_cnt  <= '0;
      bank_reg <= '0;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= 1'b0;
      if (clearing) begin
        clr_cnt <= clr_cnt + LA'(1);
        if (clr_cnt == LA'(DEPTH - 1)) begin
          state <= READY;
        end
      end else begin
        rd_pend <= bus.CS & bus.RD & ~bus.WR;
        if (bus.bank_wr) begin
          bank_reg <= bus.bank_din[BW-1:0];
        end
      end
    end
  end

  sp_ram_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .q    (ram_q)
  );

  assign bus.D_out    = rd_pend ? ram_q : OPEN_BUS[DATA_W-1:0];
  assign bus.rd_valid = rd_pend;
  assign bus.bank_q   = 8'(bank_reg);
  assign bus.busy     = clearing;

endmodule

// File: tb/tb_banked_sram.sv
// Randomised scoreboard bench for banked_sram (ADDR_W=4, BANKS=4, CLEAR_VAL=A5).
module tb_banked_sram;

  localparam int          AW    = 4;
  localparam int          NB    = 4;
  localparam int          WORDS = 16;
  localparam logic [7:0]  CV    = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  banked_sram_if #(.DATA_W(8), .ADDR_W(AW)) bus ();

  banked_sram #(
    .DATA_W     (8),
    .ADDR_W     (AW),
    .BANKS      (NB),
    .BANK0_AS_1 (1),
    .CLEAR_VAL  (CV),
    .CLEAR_EN   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mm [NB][WORDS];
  int         mbank = 0;
  int         passes = 0;
  int         total = 0;
  int         cyc = 0;
  int         left = 0;
  bit         seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int eff(input int b);
    return (b == 0) ? 1 : b;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < WORDS; a++) mm[b][a] = CV;
    mbank = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.CS = 1'b0; bus.WR = 1'b0; bus.RD = 1'b0; bus.bank_wr = 1'b0;
  endtask

  // One READY-state bus cycle; the model applies the access with the old bank, then the bank load.
  task automatic op(input bit cs, input bit wr, input bit rd, input int a,
                    input logic [7:0] d, input bit bw, input logic [7:0] bd);
    int e;
    e = eff(mbank);
    bus.CS = cs; bus.WR = wr; bus.RD = rd; bus.A = AW'(a); bus.D_in = d;
    bus.bank_wr = bw; bus.bank_din = bd;
    if (cs && wr) mm[e][a] = d;
    else if (cs && rd) sb.push_back('{d: mm[e][a], due: cyc + 1});
    if (bw) mbank = int'(bd) % NB;
    tick();
  endtask

  task automatic wr(input int a, input logic [7:0] d); op(1, 1, 0, a, d, 0, 8'h00); endtask
  task automatic rd(input int a);                      op(1, 0, 1, a, 8'h00, 0, 8'h00); endtask
  task automatic setbank(input logic [7:0] b);         op(0, 0, 0, 0, 8'h00, 1, b); endtask

  // Counts busy cycles after reset release, poking the bus meanwhile; bounded so it cannot hang.
  task automatic measure_busy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      if (n == 2) begin bus.CS = 1; bus.WR = 1; bus.A = '0; bus.D_in = 8'hFF; end
      if (n == 3) begin bus.CS = 1; bus.RD = 1; bus.A = '0; end
      if (n == 4) begin bus.bank_wr = 1; bus.bank_din = 8'h02; end
      if (n == 5) begin bus.CS = 1; bus.RD = 1; bus.A = AW'(5); end
      @(posedge clk);
      #1;
      bus.CS = 1'b0; bus.WR = 1'b0; bus.RD = 1'b0; bus.bank_wr = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      left <= 64;
      seen <= 1'b1;
    end else if (left > 0) begin
      left <= left - 1;
    end
  end

  always @(negedge clk) begin
    if (seen) begin
      chk("busy", 32'(bus.busy), 32'(left > 0));
      if (sb.size() > 0 && sb[0].due == cyc) begin
        chk("rd_valid", 32'(bus.rd_valid), 32'd1);
        chk("rd_data", 32'(bus.D_out), 32'(sb[0].d));
        void'(sb.pop_front());
      end else begin
        chk("rd_valid_idle", 32'(bus.rd_valid), 32'd0);
        chk("open_bus", 32'(bus.D_out), 32'hFF);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int kind;
    bus.A = '0; bus.D_in = '0; bus.CS = 0; bus.WR = 0; bus.RD = 0;
    bus.bank_wr = 0; bus.bank_din = '0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();

    chk("reset_bank_q", 32'(bus.bank_q), 32'd0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("reset_d_out", 32'(bus.D_out), 32'hFF);
    chk("reset_busy", 32'(bus.busy), 32'd1);

    measure_busy(n);
    chk("clear_cycles", 32'(n), 32'd64);
    chk("bank_wr_dropped_in_clear", 32'(bus.bank_q), 32'd0);

    // Sweep every word of every bank after the clear.
    for (int b = 0; b < NB; b++) begin
      setbank(8'(b));
      for (int a = 0; a < WORDS; a++) rd(a);
    end

    setbank(8'h02); wr(3, 8'h11);
    setbank(8'h03); wr(3, 8'h22);
    setbank(8'h02); rd(3);
    setbank(8'h03); rd(3);
    setbank(8'h01); rd(3);

    setbank(8'h00);
    chk("bank_q_zero", 32'(bus.bank_q), 32'd0);
    wr(0, 8'h5A);
    setbank(8'h01); rd(0);

    setbank(8'h02);
    op(1, 0, 1, 3, 8'h00, 1, 8'h03);
    rd(3);
    chk("bank_q_three", 32'(bus.bank_q), 32'd3);

    setbank(8'h0F);
    chk("bank_q_masked", 32'(bus.bank_q), 32'd3);
    op(1, 1, 1, 5, 8'h77, 0, 8'h00);
    rd(5);
    wr(7, 8'hC3); rd(7); rd(7); rd(6);

    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1: wr($urandom_range(0, WORDS - 1), 8'($urandom));
        2, 3: rd($urandom_range(0, WORDS - 1));
        4:    op(1, $urandom_range(0, 1), 1, $urandom_range(0, WORDS - 1), 8'($urandom),
                 1, 8'($urandom));
        default: setbank(8'($urandom));
      endcase
      chk("bank_q_rand", 32'(bus.bank_q), 32'(mbank));
    end

    // Reset landing while the clear counter sits at 20.
    setbank(8'h03);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    measure_busy(n);
    chk("midclear_restart_cycles", 32'(n), 32'd64);
    chk("midclear_bank_q", 32'(bus.bank_q), 32'd0);
    rd(0); rd(3); rd(15);
    setbank(8'h02); rd(3);

    repeat (4) tick();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
